// File: rtl/ofm_writeback_if.sv
// ---------------------------------------------------------------------------
// ofm_writeback_if
//   Write-only word bus between the OFM write-back stage and the next layer's
//   feature-map RAM. A beat is transferred on every rising clock edge where
//   wr=1 and waitrequest=0. While waitrequest=1 the master keeps wr, addr
//   and writedata stable.
//
//   Parameters
//     ADDR_WIDTH  word address width
//     WW          data word width (DATA_WIDTH * WORD_PIXELS)
//
//   Signals
//     wr           master -> slave  write request
//     addr         master -> slave  word address
//     writedata    master -> slave  packed pixels, lowest pixel at LSB
//     waitrequest  slave -> master  1 = slave stalls the current beat
// ---------------------------------------------------------------------------
interface ofm_writeback_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int WW         = 32
);
  logic                  wr;
  logic [ADDR_WIDTH-1:0] addr;
  logic [WW-1:0]         writedata;
  logic                  waitrequest;

  modport master (
    output wr,
    output addr,
    output writedata,
    input  waitrequest
  );

  modport slave (
    input  wr,
    input  addr,
    input  writedata,
    output waitrequest
  );
endinterface

// File: rtl/ofm_writeback.sv
// ---------------------------------------------------------------------------
// ofm_writeback
//   Write-back stage behind the single-channel conv/pool/ReLU engine. On the
//   engine's finish pulse (start) the whole flat OFM vector is copied into a
//   shadow register, so the engine may begin the next channel immediately.
//   The shadow is then streamed as packed words over a wr/waitrequest bus.
//
//   Optional feature macro: OFM_WB_CHECKSUM_EN
//     defined     : checksum accumulates (mod 2^32) every accepted writedata
//     not defined : checksum is tied to zero, no accumulator is built
//
//   Ports
//     clk       in   rising-edge clock
//     rst       in   asynchronous reset, active-high
//     start     in   1-cycle pulse, OFM valid
//     ofm       in   flat OFM, pixel k at [k*DATA_WIDTH +: DATA_WIDTH]
//     bus       master modport of ofm_writeback_if (wr/addr/writedata/waitrequest)
//     busy      out  high from the cycle after an accepted start until done
//     done      out  1-cycle pulse after the last accepted beat
//     overrun   out  sticky: start seen while busy (WRITE or DONE)
//     checksum  out  running sum of accepted words (see macro above)
// ---------------------------------------------------------------------------
module ofm_writeback #(
  parameter int DATA_WIDTH  = 8,
  parameter int MAP_SIZE    = 16,
  parameter int WORD_PIXELS = 4,
  parameter int ADDR_WIDTH  = 9,
  parameter int BASE_ADDR   = 0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [DATA_WIDTH*MAP_SIZE*MAP_SIZE-1:0] ofm,
  ofm_writeback_if.master                       bus,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  overrun,
  output logic [31:0]                           checksum
);

  localparam int OFM_W     = DATA_WIDTH * MAP_SIZE * MAP_SIZE;
  localparam int WW        = DATA_WIDTH * WORD_PIXELS;
  localparam int NUM_WORDS = (MAP_SIZE * MAP_SIZE) / WORD_PIXELS;
  localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WW-1:0]         writedata_q, writedata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  overrun_q, overrun_d;

  // The shadow holds the words not yet loaded into writedata. It shifts down
  // by one word per accepted beat, so the next word is always at the bottom
  // and no wide read multiplexer is needed.
  logic [OFM_W-1:0]      shadow_q;
  logic                  load_shadow;
  logic                  shift_shadow;
  logic                  last_word;
  logic                  beat_accepted;

`ifdef OFM_WB_CHECKSUM_EN
  logic [31:0]           checksum_q, checksum_d;
  logic [WW+31:0]        writedata_ext;
`endif

  assign last_word     = (idx_q == IDX_W'(NUM_WORDS - 1));
  assign beat_accepted = wr_q && !bus.waitrequest;

`ifdef OFM_WB_CHECKSUM_EN
  // Zero-extend before truncating so any word width folds in mod 2^32.
  assign writedata_ext = {32'd0, writedata_q};
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    writedata_d  = writedata_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    overrun_d    = overrun_q;
    load_shadow  = 1'b0;
    shift_shadow = 1'b0;
`ifdef OFM_WB_CHECKSUM_EN
    checksum_d   = checksum_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // First word goes straight from the input so beat 0 is on the bus
          // in the very next cycle.
          load_shadow = 1'b1;
          idx_d       = '0;
          overrun_d   = 1'b0;
          busy_d      = 1'b1;
          wr_d        = 1'b1;
          addr_d      = ADDR_WIDTH'(BASE_ADDR);
          writedata_d = ofm[WW-1:0];
          state_d     = S_WRITE;
`ifdef OFM_WB_CHECKSUM_EN
          checksum_d  = 32'd0;
`endif
        end
      end

      S_WRITE: begin
        if (start) begin
          overrun_d = 1'b1;
        end
        if (beat_accepted) begin
`ifdef OFM_WB_CHECKSUM_EN
          checksum_d = checksum_q + writedata_ext[31:0];
`endif
          if (last_word) begin
            wr_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            idx_d        = idx_q + 1'b1;
            addr_d       = addr_q + 1'b1;
            writedata_d  = shadow_q[WW-1:0];
            shift_shadow = 1'b1;
          end
        end
      end

      S_DONE: begin
        // The engine should not finish again before done has been seen.
        if (start) begin
          overrun_d = 1'b1;
        end
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      writedata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      writedata_q <= writedata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
    end
  end

  // Pure data storage: its content only matters after a load, so no reset.
  always_ff @(posedge clk) begin
    if (load_shadow) begin
      shadow_q <= ofm >> WW;
    end else if (shift_shadow) begin
      shadow_q <= shadow_q >> WW;
    end
  end

`ifdef OFM_WB_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum_q <= 32'd0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = 32'd0;
`endif

  assign bus.wr        = wr_q;
  assign bus.addr      = addr_q;
  assign bus.writedata = writedata_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_ofm_writeback.sv
// ---------------------------------------------------------------------------
// tb_ofm_writeback
//   Bench for ofm_writeback with default parameters. The stimulus side keeps
//   the OFM as a pixel array, predicts the word stream and the final checksum
//   for each start it issues and queues them; an independent monitor pops a
//   prediction for every accepted beat and checks done/checksum. A small
//   driver process produces waitrequest (none, random, or a fixed 3-cycle
//   stall on address 10).
// ---------------------------------------------------------------------------
module tb_ofm_writeback;

  localparam int DATA_WIDTH  = 8;
  localparam int MAP_SIZE    = 16;
  localparam int WORD_PIXELS = 4;
  localparam int ADDR_WIDTH  = 9;
  localparam int BASE_ADDR   = 0;
  localparam int NPIX        = MAP_SIZE * MAP_SIZE;
  localparam int NUM_WORDS   = NPIX / WORD_PIXELS;
  localparam int WW          = DATA_WIDTH * WORD_PIXELS;

  typedef struct {
    logic [ADDR_WIDTH-1:0] addr;
    logic [WW-1:0]         data;
  } beat_t;

  logic                         clk = 1'b0;
  logic                         rst;
  logic                         start;
  logic [DATA_WIDTH*NPIX-1:0]   ofm;
  logic                         busy;
  logic                         done;
  logic                         overrun;
  logic [31:0]                  checksum;
  logic                         wreq;

  logic [DATA_WIDTH-1:0]        pix [NPIX];
  beat_t                        beat_q [$];
  logic [31:0]                  exp_cks;
  bit                           expect_done;
  int                           wmode;
  int                           stalls;
  int                           checks;
  int                           errors;

  ofm_writeback_if #(.ADDR_WIDTH(ADDR_WIDTH), .WW(WW)) bus ();

  ofm_writeback #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAP_SIZE   (MAP_SIZE),
    .WORD_PIXELS(WORD_PIXELS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BASE_ADDR  (BASE_ADDR)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .ofm     (ofm),
    .bus     (bus),
    .busy    (busy),
    .done    (done),
    .overrun (overrun),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  assign bus.waitrequest = wreq;

  always_comb begin
    ofm = '0;
    for (int k = 0; k < NPIX; k++) ofm[k*DATA_WIDTH +: DATA_WIDTH] = pix[k];
  end

  // waitrequest changes just after the rising edge, stable at the sample point.
  always @(posedge clk) begin
    #1;
    case (wmode)
      1: wreq = ($urandom_range(0, 3) == 0);
      2: begin
        if (bus.wr && bus.addr == ADDR_WIDTH'(10) && stalls < 3) begin
          wreq = 1'b1;
          stalls++;
        end else begin
          wreq = 1'b0;
        end
      end
      default: wreq = 1'b0;
    endcase
  end

  // Monitor: every accepted beat must match the oldest prediction.
  always @(negedge clk) begin
    beat_t b;
    if (!rst) begin
      if (bus.wr && !wreq) begin
        checks++;
        if (beat_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: addr=%0d data=%h, no beat expected", bus.addr, bus.writedata);
        end else begin
          b = beat_q.pop_front();
          if (bus.addr !== b.addr || bus.writedata !== b.data) begin
            errors++;
            $display("FAIL beat: got addr=%0d data=%h, expected addr=%0d data=%h",
                     bus.addr, bus.writedata, b.addr, b.data);
          end
        end
      end
      if (done) begin
        checks++;
        if (!expect_done || beat_q.size() != 0) begin
          errors++;
          $display("FAIL done_pulse: done=1 with expect_done=%0d and %0d beats outstanding",
                   expect_done, beat_q.size());
        end
        expect_done = 1'b0;
        checks++;
        if (checksum !== exp_cks) begin
          errors++;
          $display("FAIL checksum: got %h, expected %h", checksum, exp_cks);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic set_ramp();
    for (int k = 0; k < NPIX; k++) pix[k] = DATA_WIDTH'(k);
  endtask

  task automatic set_random();
    for (int k = 0; k < NPIX; k++) pix[k] = DATA_WIDTH'($urandom);
  endtask

  // One transfer. extra_at: 0 none, >0 second start on that cycle, -1 on done.
  // rst_at: cycle on which reset is asserted (0 = never). exp_done: 0 = don't care.
  task automatic run_xfer(input int stall_mode, input int extra_at, input bit chg_c1,
                          input int rst_at, input int exp_done, input string name);
    int          cyc;
    bit          busy_bad;
    bit          got_done;
    bit          was_reset;
    logic [31:0] w;
    logic [31:0] sum;
    @(negedge clk);
    wmode  = stall_mode;
    stalls = 0;
    sum    = 32'd0;
    for (int wi = 0; wi < NUM_WORDS; wi++) begin
      w = '0;
      for (int j = 0; j < WORD_PIXELS; j++)
        w = w | (32'(pix[wi*WORD_PIXELS + j]) << (DATA_WIDTH * j));
      beat_q.push_back('{addr: ADDR_WIDTH'(BASE_ADDR + wi), data: w});
      sum = sum + w;
    end
`ifdef OFM_WB_CHECKSUM_EN
    exp_cks = sum;
`else
    exp_cks = 32'd0;
`endif
    expect_done = 1'b1;
    start       = 1'b1;
    cyc = 0; busy_bad = 0; got_done = 0; was_reset = 0;
    while (!got_done && !was_reset && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        check({name, "_c1_wr_busy_ovr"}, {61'd0, bus.wr, busy, overrun}, 64'b110);
        if (chg_c1) for (int k = 0; k < NPIX; k++) pix[k] = 8'hAA;
      end
      if (done) begin
        got_done = 1'b1;
        check({name, "_busy_at_done"}, 64'(busy), 64'd0);
        if (extra_at == -1) start = 1'b1;
      end else if (!busy) begin
        busy_bad = 1'b1;
      end
      if (extra_at > 0 && cyc == extra_at) begin
        start = 1'b1;
        set_random();
      end
      if (extra_at > 0 && cyc == extra_at + 1) start = 1'b0;
      if (rst_at != 0 && cyc == rst_at) begin
        rst = 1'b1;
        #1;
        check({name, "_rst_wr_busy_done"}, {61'd0, bus.wr, busy, done}, 64'd0);
        beat_q.delete();
        expect_done = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        was_reset = 1'b1;
      end
    end
    if (was_reset) begin
      busy_bad = 1'b0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (bus.wr || busy || done) busy_bad = 1'b1;
      end
      check({name, "_quiet_after_rst"}, 64'(busy_bad), 64'd0);
    end else begin
      checks++;
      if (!got_done) begin
        errors++;
        $display("FAIL %s_timeout: no done within %0d cycles, required done", name, cyc);
      end
      check({name, "_busy_during"}, 64'(busy_bad), 64'd0);
      if (exp_done != 0) check({name, "_done_cycle"}, 64'(cyc), 64'(exp_done));
      @(negedge clk);
      start = 1'b0;
      check({name, "_overrun_after"}, 64'(overrun), 64'(extra_at != 0));
      check({name, "_idle_after"}, {62'd0, busy, done}, 64'd0);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; start = 1'b0; wreq = 1'b0; wmode = 0; stalls = 0;
    expect_done = 1'b0; exp_cks = 32'd0;
    set_ramp();
    repeat (3) @(negedge clk);
    check("reset_ctrl", {60'd0, bus.wr, busy, done, overrun}, 64'd0);
    check("reset_addr", 64'(bus.addr), 64'd0);
    check("reset_data", 64'(bus.writedata), 64'd0);
    check("reset_checksum", 64'(checksum), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    set_ramp();   run_xfer(0, 0, 0, 0, NUM_WORDS + 1, "ramp");
    set_ramp();   run_xfer(2, 0, 0, 0, NUM_WORDS + 4, "stall10");
    set_random(); run_xfer(0, 20, 0, 0, NUM_WORDS + 1, "overrun_write");
    set_random(); run_xfer(0, 0, 0, 0, NUM_WORDS + 1, "after_overrun");
    set_random(); run_xfer(0, -1, 0, 0, NUM_WORDS + 1, "overrun_done");
    set_ramp();   run_xfer(0, 0, 1, 0, NUM_WORDS + 1, "ofm_change");
    set_ramp();   run_xfer(0, 0, 0, 30, 0, "reset_mid");
    set_ramp();   run_xfer(0, 0, 0, 0, NUM_WORDS + 1, "after_reset");
    for (int r = 0; r < 4; r++) begin
      set_random(); run_xfer(1, 0, 0, 0, 0, "random");
    end
    wmode = 0;
    repeat (3) @(negedge clk);
    check("queue_drained", 64'(beat_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
